// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
//
// Shares the single write port of the 32 x 64-bit register file between two
// writers: requester 0 (ALU writeback) and requester 1 (load/memory return).
// Each requester owns a one-entry holding buffer behind a valid/ready
// handshake. A buffered write is granted combinationally and issued on the
// register file port one edge later, so at most one write per cycle reaches the
// register file.
//
// Arbitration:
//   - one buffer full        : grant it
//   - both full, rd differs  : round-robin pointer decides
//   - both full, same rd     : older buffer wins, preserving write order
//   After every grant the pointer prefers the requester that was not granted.
//
// Ports:
//   clk                      rising-edge clock
//   reset                    asynchronous, active-low reset
//   reqN_valid/ready         handshake, N = 0 (ALU) or 1 (load return)
//   reqN_rd, reqN_data       destination register and data
//   RegWrite                 register file write enable, one cycle per write
//   WriteReg, WriteData      register file write index and data (held when idle)
//   idle                     both buffers empty and RegWrite low
//
// Optional feature (macro REGARB_FWD_EN):
//   fwd_rs1/fwd_rs2          read addresses to look up
//   fwd_hit1/fwd_hit2        a pending or issuing write targets that register
//   fwd_data1/fwd_data2      newest pending data for that register
//   Lookup order: younger full buffer, older full buffer, output stage.
//   Register 0 never hits.
// -----------------------------------------------------------------------------
module regfile_write_arbiter #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_rd,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_rd,
  input  logic [DATA_W-1:0] req1_data,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteReg,
  output logic [DATA_W-1:0] WriteData,
  output logic              idle
`ifdef REGARB_FWD_EN
  ,
  input  logic [ADDR_W-1:0] fwd_rs1,
  input  logic [ADDR_W-1:0] fwd_rs2,
  output logic              fwd_hit1,
  output logic              fwd_hit2,
  output logic [DATA_W-1:0] fwd_data1,
  output logic [DATA_W-1:0] fwd_data2
`endif
);

  // Holding buffers
  logic              buf0_full_q, buf0_full_d;
  logic [ADDR_W-1:0] buf0_rd_q,   buf0_rd_d;
  logic [DATA_W-1:0] buf0_data_q, buf0_data_d;
  logic              buf1_full_q, buf1_full_d;
  logic [ADDR_W-1:0] buf1_rd_q,   buf1_rd_d;
  logic [DATA_W-1:0] buf1_data_q, buf1_data_d;

  // age_q names the most recently filled (younger) buffer: 0 = buf0, 1 = buf1.
  logic age_q, age_d;
  // ptr_q: 0 prefers req0, 1 prefers req1 on a contended different-rd grant.
  logic ptr_q, ptr_d;

  // Output stage
  logic              regwrite_q,   regwrite_d;
  logic [ADDR_W-1:0] write_reg_q,  write_reg_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;

  logic grant0, grant1;
  logic fill0, fill1;

  // ---------------------------------------------------------------------------
  // Grant: purely from registered buffer state.
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (buf0_full_q && buf1_full_q) begin
      if (buf0_rd_q == buf1_rd_q) begin
        // Same destination: the older buffer goes first so the younger value
        // is the one left in the register file.
        if (age_q) grant0 = 1'b1;
        else       grant1 = 1'b1;
      end else if (ptr_q) begin
        grant1 = 1'b1;
      end else begin
        grant0 = 1'b1;
      end
    end else if (buf0_full_q) begin
      grant0 = 1'b1;
    end else if (buf1_full_q) begin
      grant1 = 1'b1;
    end
  end

  // Ready depends only on registered state (plus reset), never on valid.
  // A granted buffer drains this edge, so it can take a new entry at once.
  assign req0_ready = reset & (~buf0_full_q | grant0);
  assign req1_ready = reset & (~buf1_full_q | grant1);

  // A transfer to register 0 is accepted but never occupies the buffer.
  assign fill0 = req0_valid & req0_ready & (req0_rd != '0);
  assign fill1 = req1_valid & req1_ready & (req1_rd != '0);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    buf0_full_d  = fill0 | (buf0_full_q & ~grant0);
    buf0_rd_d    = fill0 ? req0_rd   : buf0_rd_q;
    buf0_data_d  = fill0 ? req0_data : buf0_data_q;
    buf1_full_d  = fill1 | (buf1_full_q & ~grant1);
    buf1_rd_d    = fill1 ? req1_rd   : buf1_rd_q;
    buf1_data_d  = fill1 ? req1_data : buf1_data_q;

    age_d = age_q;
    if (fill0 && fill1) begin
      // Simultaneous fills: req0 counts as older, so buf1 is the younger.
      age_d = 1'b1;
    end else if (fill0 && buf1_full_q && !grant1) begin
      age_d = 1'b0;
    end else if (fill1 && buf0_full_q && !grant0) begin
      age_d = 1'b1;
    end

    ptr_d = ptr_q;
    if (grant0)      ptr_d = 1'b1;
    else if (grant1) ptr_d = 1'b0;

    regwrite_d   = grant0 | grant1;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if (grant0) begin
      write_reg_d  = buf0_rd_q;
      write_data_d = buf0_data_q;
    end else if (grant1) begin
      write_reg_d  = buf1_rd_q;
      write_data_d = buf1_data_q;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf0_full_q  <= 1'b0;
      buf0_rd_q    <= '0;
      buf0_data_q  <= '0;
      buf1_full_q  <= 1'b0;
      buf1_rd_q    <= '0;
      buf1_data_q  <= '0;
      age_q        <= 1'b0;
      ptr_q        <= 1'b0;
      regwrite_q   <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      buf0_full_q  <= buf0_full_d;
      buf0_rd_q    <= buf0_rd_d;
      buf0_data_q  <= buf0_data_d;
      buf1_full_q  <= buf1_full_d;
      buf1_rd_q    <= buf1_rd_d;
      buf1_data_q  <= buf1_data_d;
      age_q        <= age_d;
      ptr_q        <= ptr_d;
      regwrite_q   <= regwrite_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

  assign RegWrite  = regwrite_q;
  assign WriteReg  = write_reg_q;
  assign WriteData = write_data_q;
  assign idle      = ~buf0_full_q & ~buf1_full_q & ~regwrite_q;

`ifdef REGARB_FWD_EN
  // ---------------------------------------------------------------------------
  // Forwarding: newest pending value for a read address.
  // ---------------------------------------------------------------------------
  logic              young_full, old_full;
  logic [ADDR_W-1:0] young_rd,   old_rd;
  logic [DATA_W-1:0] young_data, old_data;

  always_comb begin
    young_full = age_q ? buf1_full_q : buf0_full_q;
    young_rd   = age_q ? buf1_rd_q   : buf0_rd_q;
    young_data = age_q ? buf1_data_q : buf0_data_q;
    old_full   = age_q ? buf0_full_q : buf1_full_q;
    old_rd     = age_q ? buf0_rd_q   : buf1_rd_q;
    old_data   = age_q ? buf0_data_q : buf1_data_q;

    fwd_hit1  = 1'b0;
    fwd_data1 = '0;
    if (fwd_rs1 != '0) begin
      if (young_full && young_rd == fwd_rs1) begin
        fwd_hit1  = 1'b1;
        fwd_data1 = young_data;
      end else if (old_full && old_rd == fwd_rs1) begin
        fwd_hit1  = 1'b1;
        fwd_data1 = old_data;
      end else if (regwrite_q && write_reg_q == fwd_rs1) begin
        fwd_hit1  = 1'b1;
        fwd_data1 = write_data_q;
      end
    end

    fwd_hit2  = 1'b0;
    fwd_data2 = '0;
    if (fwd_rs2 != '0) begin
      if (young_full && young_rd == fwd_rs2) begin
        fwd_hit2  = 1'b1;
        fwd_data2 = young_data;
      end else if (old_full && old_rd == fwd_rs2) begin
        fwd_hit2  = 1'b1;
        fwd_data2 = old_data;
      end else if (regwrite_q && write_reg_q == fwd_rs2) begin
        fwd_hit2  = 1'b1;
        fwd_data2 = write_data_q;
      end
    end
  end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_write_arbiter
//
// Directed bench for regfile_write_arbiter. Each table row is one clock cycle:
// the row's inputs are presented during the cycle and the row's expected
// outputs are the ones visible during that same cycle (ready from current
// buffer state, RegWrite/WriteReg/WriteData from the previous edge).
// Hand-written sequences cover reset in mid-operation and, when REGARB_FWD_EN
// is defined, register forwarding.
// -----------------------------------------------------------------------------
module tb_regfile_write_arbiter;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;

  logic              clk;
  logic              reset;
  logic              req0_valid, req1_valid;
  logic              req0_ready, req1_ready;
  logic [ADDR_W-1:0] req0_rd, req1_rd;
  logic [DATA_W-1:0] req0_data, req1_data;
  logic              RegWrite;
  logic [ADDR_W-1:0] WriteReg;
  logic [DATA_W-1:0] WriteData;
  logic              idle;
`ifdef REGARB_FWD_EN
  logic [ADDR_W-1:0] fwd_rs1, fwd_rs2;
  logic              fwd_hit1, fwd_hit2;
  logic [DATA_W-1:0] fwd_data1, fwd_data2;
`endif

  regfile_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_rd    (req0_rd),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_rd    (req1_rd),
    .req1_data  (req1_data),
    .RegWrite   (RegWrite),
    .WriteReg   (WriteReg),
    .WriteData  (WriteData),
    .idle       (idle)
`ifdef REGARB_FWD_EN
    ,
    .fwd_rs1    (fwd_rs1),
    .fwd_rs2    (fwd_rs2),
    .fwd_hit1   (fwd_hit1),
    .fwd_hit2   (fwd_hit2),
    .fwd_data1  (fwd_data1),
    .fwd_data2  (fwd_data2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              v0;
    logic [ADDR_W-1:0] rd0;
    logic [DATA_W-1:0] d0;
    logic              v1;
    logic [ADDR_W-1:0] rd1;
    logic [DATA_W-1:0] d1;
    logic              rdy0;
    logic              rdy1;
    logic              we;
    logic [ADDR_W-1:0] wreg;
    logic [DATA_W-1:0] wdata;
    logic              idl;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic v0, input int rd0, input logic [63:0] d0,
                     input logic v1, input int rd1, input logic [63:0] d1,
                     input logic rdy0, input logic rdy1, input logic we,
                     input int wreg, input logic [63:0] wdata, input logic idl);
    vec_t v;
    v.v0 = v0;  v.rd0 = ADDR_W'(rd0);  v.d0 = d0;
    v.v1 = v1;  v.rd1 = ADDR_W'(rd1);  v.d1 = d1;
    v.rdy0 = rdy0;  v.rdy1 = rdy1;  v.we = we;
    v.wreg = ADDR_W'(wreg);  v.wdata = wdata;  v.idl = idl;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic v0, input int rd0, input logic [63:0] d0,
                       input logic v1, input int rd1, input logic [63:0] d1);
    req0_valid = v0;  req0_rd = ADDR_W'(rd0);  req0_data = d0;
    req1_valid = v1;  req1_rd = ADDR_W'(rd1);  req1_data = d1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hard stop in case the bench ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    drive(1'b0, 0, 64'h0, 1'b0, 0, 64'h0);
`ifdef REGARB_FWD_EN
    fwd_rs1 = '0;
    fwd_rs2 = '0;
`endif

    //  v0 rd0 d0          v1 rd1 d1          rdy0 rdy1 we wreg wdata      idle
    // Contended pair after reset, pointer prefers req0: rd3 then rd4.
    add(1, 3, 64'h30,    1, 4, 64'h40,    1, 1, 0, 0,  64'h0,   1);
    add(0, 0, 64'h0,     0, 0, 64'h0,     1, 0, 0, 0,  64'h0,   0);
    add(0, 0, 64'h0,     0, 0, 64'h0,     1, 1, 1, 3,  64'h30,  0);
    add(0, 0, 64'h0,     0, 0, 64'h0,     1, 1, 1, 4,  64'h40,  0);
    // Single write rd5 = 0xA5: RegWrite one cycle after the accept edge.
    add(1, 5, 64'hA5,    0, 0, 64'h0,     1, 1, 0, 4,  64'h40,  1);
    add(0, 0, 64'h0,     0, 0, 64'h0,     1, 1, 0, 4,  64'h40,  0);
    add(0, 0, 64'h0,     0, 0, 64'h0,     1, 1, 1, 5,  64'hA5,  0);
    // Pointer now prefers req1: rd7 (req1) first, then rd6.
    add(1, 6, 64'h60,    1, 7, 64'h70,    1, 1, 0, 5,  64'hA5,  1);
    add(0, 0, 64'h0,     0, 0, 64'h0,     0, 1, 0, 5,  64'hA5,  0);
    add(0, 0, 64'h0,     0, 0, 64'h0,     1, 1, 1, 7,  64'h70,  0);
    add(0, 0, 64'h0,     0, 0, 64'h0,     1, 1, 1, 6,  64'h60,  0);
    add(0, 0, 64'h0,     0, 0, 64'h0,     1, 1, 0, 6,  64'h60,  1);
    // Same rd, buf1 older: 0x11 must land before 0x22.
    add(0, 0, 64'h0,     1, 2, 64'h02,    1, 1, 0, 6,  64'h60,  1);
    add(1, 8, 64'h88,    1, 9, 64'h11,    1, 1, 0, 6,  64'h60,  0);
    add(1, 9, 64'h22,    0, 0, 64'h0,     1, 0, 1, 2,  64'h02,  0);
    add(0, 0, 64'h0,     0, 0, 64'h0,     0, 1, 1, 8,  64'h88,  0);
    add(0, 0, 64'h0,     0, 0, 64'h0,     1, 1, 1, 9,  64'h11,  0);
    add(0, 0, 64'h0,     0, 0, 64'h0,     1, 1, 1, 9,  64'h22,  0);
    // Same rd filled on the same edge while pointer prefers req1: req0 older.
    add(1, 10, 64'hA0,   1, 10, 64'hB0,   1, 1, 0, 9,  64'h22,  1);
    add(0, 0, 64'h0,     0, 0, 64'h0,     1, 0, 0, 9,  64'h22,  0);
    add(0, 0, 64'h0,     0, 0, 64'h0,     1, 1, 1, 10, 64'hA0,  0);
    add(0, 0, 64'h0,     0, 0, 64'h0,     1, 1, 1, 10, 64'hB0,  0);
    // req0 writes rd0 (discarded) while req1 streams rd1..4 at full rate.
    add(1, 0, 64'hFF,    1, 1, 64'h101,   1, 1, 0, 10, 64'hB0,  1);
    add(1, 0, 64'hFF,    1, 2, 64'h102,   1, 1, 0, 10, 64'hB0,  0);
    add(1, 0, 64'hFF,    1, 3, 64'h103,   1, 1, 1, 1,  64'h101, 0);
    add(1, 0, 64'hFF,    1, 4, 64'h104,   1, 1, 1, 2,  64'h102, 0);
    add(0, 0, 64'h0,     0, 0, 64'h0,     1, 1, 1, 3,  64'h103, 0);
    add(0, 0, 64'h0,     0, 0, 64'h0,     1, 1, 1, 4,  64'h104, 0);
    add(0, 0, 64'h0,     0, 0, 64'h0,     1, 1, 0, 4,  64'h104, 1);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset RegWrite",   64'(RegWrite),   64'h0);
    check("reset WriteReg",   64'(WriteReg),   64'h0);
    check("reset WriteData",  WriteData,       64'h0);
    check("reset req0_ready", 64'(req0_ready), 64'h0);
    check("reset req1_ready", 64'(req1_ready), 64'h0);
    check("reset idle",       64'(idle),       64'h1);
    reset = 1'b1;

    // Table-driven cycles.
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].v0, int'(vecs[i].rd0), vecs[i].d0,
            vecs[i].v1, int'(vecs[i].rd1), vecs[i].d1);
      #1;
      check($sformatf("row%0d req0_ready", i), 64'(req0_ready), 64'(vecs[i].rdy0));
      check($sformatf("row%0d req1_ready", i), 64'(req1_ready), 64'(vecs[i].rdy1));
      check($sformatf("row%0d RegWrite", i),   64'(RegWrite),   64'(vecs[i].we));
      check($sformatf("row%0d WriteReg", i),   64'(WriteReg),   64'(vecs[i].wreg));
      check($sformatf("row%0d WriteData", i),  WriteData,       vecs[i].wdata);
      check($sformatf("row%0d idle", i),       64'(idle),       64'(vecs[i].idl));
      tick();
    end

    // Reset asserted with both buffers full: buffered writes are dropped.
    drive(1'b1, 11, 64'h1111, 1'b1, 12, 64'h1212);
    tick();
    check("pre-reset req1_ready", 64'(req1_ready), 64'h0);
    check("pre-reset idle",       64'(idle),       64'h0);
    check("pre-reset WriteReg",   64'(WriteReg),   64'h4);
    reset = 1'b0;
    #1;
    check("mid-reset RegWrite",   64'(RegWrite),   64'h0);
    check("mid-reset WriteReg",   64'(WriteReg),   64'h0);
    check("mid-reset WriteData",  WriteData,       64'h0);
    check("mid-reset req0_ready", 64'(req0_ready), 64'h0);
    check("mid-reset req1_ready", 64'(req1_ready), 64'h0);
    check("mid-reset idle",       64'(idle),       64'h1);
    repeat (2) tick();
    check("held-reset req0_ready", 64'(req0_ready), 64'h0);
    check("held-reset RegWrite",   64'(RegWrite),   64'h0);
    drive(1'b0, 0, 64'h0, 1'b0, 0, 64'h0);
    reset = 1'b1;
    #1;
    check("post-reset req0_ready", 64'(req0_ready), 64'h1);
    check("post-reset req1_ready", 64'(req1_ready), 64'h1);
    check("post-reset idle",       64'(idle),       64'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("post-reset cyc%0d RegWrite", i), 64'(RegWrite), 64'h0);
      check($sformatf("post-reset cyc%0d idle", i),     64'(idle),     64'h1);
    end

`ifdef REGARB_FWD_EN
    // Forwarding from a full buffer, then from the output stage.
    drive(1'b1, 12, 64'hBEEF, 1'b0, 0, 64'h0);
    tick();
    drive(1'b0, 0, 64'h0, 1'b0, 0, 64'h0);
    fwd_rs1 = 5'd12;
    fwd_rs2 = 5'd0;
    #1;
    check("fwd buf hit1",  64'(fwd_hit1), 64'h1);
    check("fwd buf data1", fwd_data1,     64'hBEEF);
    check("fwd rs0 hit2",  64'(fwd_hit2), 64'h0);
    tick();
    check("fwd out hit1",  64'(fwd_hit1), 64'h1);
    check("fwd out data1", fwd_data1,     64'hBEEF);
    tick();
    check("fwd done hit1", 64'(fwd_hit1), 64'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
